ram_write_arbiter: RTL

Two-requester arbiter for the shared 2048-word matrix RAM write port. It sits between the number-separation write path (requester 0) and the matrix generator/result writer (requester 1), and drives the single RAM write port. Arbitration is round-robin, with an optional burst lock and per-requester beat counters. The RAM write port it drives is registered.

---
 rtl/ram_write_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ram_write_arbiter.sv
// Round-robin write-port arbiter for the shared matrix RAM, with burst lock and per-requester beat counters.
// Define RAM_ARB_ADDR_CHECK_EN to drop out-of-range beats and raise the sticky addr_err flag.
module ram_write_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_lock,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic [1:0]            req_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_W-1:0]     ram_wr_addr,
    output logic [DATA_W-1:0]     ram_wr_data,
    output logic [2*ADDR_W+1:0]   beat_count,
    output logic                  owner
`ifdef RAM_ARB_ADDR_CHECK_EN
    ,
    output logic                  addr_err
`endif
);

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("DEPTH exceeds the address space");
    end

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic                rr_next_q, rr_next_d;
    logic                lock_vld_q, lock_vld_d;
    logic                lock_id_q, lock_id_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                owner_q, owner_d;

    logic                accept;
    logic                gnt_id;
    logic                sel_lock;
    logic                addr_ok;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // A lock whose owner has dropped valid releases immediately and falls through to normal arbitration.
    always_comb begin
        req_ready = 2'b00;
        if (!clear) begin
            if (lock_vld_q && req_valid[lock_id_q]) begin
                req_ready[lock_id_q] = 1'b1;
            end else begin
                case (req_valid)
                    2'b01:   req_ready = 2'b01;
                    2'b10:   req_ready = 2'b10;
                    2'b11:   req_ready[rr_next_q] = 1'b1;
                    default: req_ready = 2'b00;
                endcase
            end
        end
    end

    assign accept   = |req_ready;
    assign gnt_id   = req_ready[1];
    assign sel_lock = req_lock[gnt_id];
    assign sel_addr = gnt_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign sel_data = gnt_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

`ifdef RAM_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    logic addr_err_q, addr_err_d;

    assign addr_ok  = ({1'b0, sel_addr} < DEPTH_LIM);
    assign addr_err = addr_err_q;

    always_comb begin
        addr_err_d = addr_err_q;
        if (clear) begin
            addr_err_d = 1'b0;
        end else if (accept && !addr_ok) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end
`else
    assign addr_ok = 1'b1;
`endif

    always_comb begin
        rr_next_d  = rr_next_q;
        lock_vld_d = lock_vld_q && req_valid[lock_id_q];
        lock_id_d  = lock_id_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        owner_d    = owner_q;
        if (clear) begin
            rr_next_d  = 1'b0;
            lock_vld_d = 1'b0;
            lock_id_d  = 1'b0;
        end else if (accept) begin
            rr_next_d  = ~gnt_id;
            lock_vld_d = sel_lock;
            lock_id_d  = gnt_id;
            wr_en_d    = addr_ok;
            // Dropped beats leave the last written address/data/owner untouched.
            if (addr_ok) begin
                wr_addr_d = sel_addr;
                wr_data_d = sel_data;
                owner_d   = gnt_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_next_q  <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            owner_q    <= 1'b0;
        end else begin
            rr_next_q  <= rr_next_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            owner_q    <= owner_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [ADDR_W:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (req_ready[gi]) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign beat_count[gi*(ADDR_W+1) +: ADDR_W+1] = cnt_q;
        end
    endgenerate

    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign owner       = owner_q;

endmodule
